// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file port controller.
//   REG_*        : geometry of the 16x16 CPU register file
//   RF_*         : encodings of the register file write control
//   rf_state_e   : controller state machine states
//   norm_write() : folds the core's dual-write request onto port 1
package regfile_pkg;

    localparam int REG_COUNT = 16;
    localparam int REG_WIDTH = 16;
    localparam int REG_IDX_W = 4;

    localparam logic [1:0] RF_RD = 2'b00;
    localparam logic [1:0] RF_W1 = 2'b01;
    localparam logic [1:0] RF_W2 = 2'b10;

    typedef enum logic [1:0] {
        ST_CLEAR     = 2'd0,
        ST_RUN       = 2'd1,
        ST_DBG_GRANT = 2'd2,
        ST_DBG_ACK   = 2'd3
    } rf_state_e;

    // Both ports carry the same bus_in, so writing both would only matter
    // when num1 != num2; the register file is defined to take port 1 only.
    function automatic logic [1:0] norm_write(input logic [1:0] w);
        return (w == 2'b11) ? RF_W1 : w;
    endfunction

endpackage

// File: rtl/regfile_ctrl_starve_timer.sv
// Debug starvation timer.
//   clk, rst  : system clock, synchronous active-high reset
//   clear     : restart the count (debug not waiting, or debug granted)
//   inc       : debug waited this cycle because the core owned the port
//   limit_hit : this waiting cycle is the LIMIT-th one; force the grant now
module starve_timer #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic limit_hit
);

    localparam logic [7:0] LIM    = 8'(LIMIT);
    localparam logic [7:0] LIM_M1 = 8'(LIMIT - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (inc && (cnt != LIM)) begin
            cnt <= cnt + 8'd1;
        end
    end

    // cnt counts cycles already waited; the current cycle is the next one,
    // so the grant fires while counting the LIMIT-th wait rather than one
    // cycle after it.
    assign limit_hit = inc && (cnt >= LIM_M1);

endmodule

// File: rtl/regfile_ctrl.sv
// Register file port controller: shares the 16x16 register file between the
// core execute path (combinational pass-through) and a debug req/ack port,
// and zeroes the file after reset.
//   clk, rst                 : system clock, synchronous active-high reset
//   core_valid/num1/num2/
//   core_write/core_data     : core access request (held while stalled)
//   core_rd1, core_rd2       : read data straight from the register file
//   core_stall               : core request not serviced this cycle
//   dbg_req/we/addr/wdata    : debug request, held until dbg_ack
//   dbg_ack, dbg_rdata       : one-cycle completion pulse and read data
//   busy                     : clear sequence in progress
//   rf_*                     : register file control and data
//
// state        | meaning
// ST_CLEAR     | zeroing r0..r15, one register per cycle, core stalled
// ST_RUN       | core owns the port; debug grant decided here
// ST_DBG_GRANT | debug access on port 1, core stalled
// ST_DBG_ACK   | dbg_ack high, core owns the port again
module regfile_ctrl
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT   = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 core_valid,
    input  logic [REG_IDX_W-1:0] core_num1,
    input  logic [REG_IDX_W-1:0] core_num2,
    input  logic [1:0]           core_write,
    input  logic [REG_WIDTH-1:0] core_data,
    output logic [REG_WIDTH-1:0] core_rd1,
    output logic [REG_WIDTH-1:0] core_rd2,
    output logic                 core_stall,
    input  logic                 dbg_req,
    input  logic                 dbg_we,
    input  logic [REG_IDX_W-1:0] dbg_addr,
    input  logic [REG_WIDTH-1:0] dbg_wdata,
    output logic                 dbg_ack,
    output logic [REG_WIDTH-1:0] dbg_rdata,
    output logic                 busy,
    output logic [REG_IDX_W-1:0] rf_num1,
    output logic [REG_IDX_W-1:0] rf_num2,
    output logic [1:0]           rf_write,
    output logic [REG_WIDTH-1:0] rf_bus_in,
    input  logic [REG_WIDTH-1:0] rf_bus_out1,
    input  logic [REG_WIDTH-1:0] rf_bus_out2
);

    localparam rf_state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    rf_state_e              state;
    rf_state_e              state_next;
    rf_state_e              eff_state;
    logic [REG_IDX_W-1:0]   clr_cnt;
    logic                   wait_inc;
    logic                   starve_clear;
    logic                   starve_hit;
    logic                   grant;

    // While rst is asserted the outputs already reflect the state reset
    // will land in, so busy/core_stall do not glitch on the release edge.
    assign eff_state = rst ? RESET_STATE : state;

    assign wait_inc     = !rst && (state == ST_RUN) && dbg_req && core_valid;
    assign starve_clear = !dbg_req || (state == ST_DBG_GRANT);
    assign grant        = !rst && (state == ST_RUN) && dbg_req &&
                          (!core_valid || starve_hit);

    starve_timer #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (starve_clear),
        .inc       (wait_inc),
        .limit_hit (starve_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RESET_STATE;
            clr_cnt   <= '0;
            dbg_ack   <= 1'b0;
            dbg_rdata <= '0;
        end else begin
            state   <= state_next;
            dbg_ack <= (state == ST_DBG_GRANT);
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
            if ((state == ST_DBG_GRANT) && !dbg_we) begin
                dbg_rdata <= rf_bus_out1;
            end
        end
    end

    always_comb begin
        state_next = state;
        rf_num1    = '0;
        rf_num2    = '0;
        rf_write   = RF_RD;
        rf_bus_in  = '0;
        busy       = 1'b0;
        core_stall = 1'b0;
        case (eff_state)
            ST_CLEAR: begin
                rf_num1    = clr_cnt;
                rf_write   = RF_W1;
                busy       = 1'b1;
                core_stall = 1'b1;
                if (clr_cnt == 4'd15) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (core_valid) begin
                    rf_num1   = core_num1;
                    rf_num2   = core_num2;
                    rf_write  = norm_write(core_write);
                    rf_bus_in = core_data;
                end
                if (grant) begin
                    state_next = ST_DBG_GRANT;
                end
            end
            ST_DBG_GRANT: begin
                rf_num1    = dbg_addr;
                rf_write   = dbg_we ? RF_W1 : RF_RD;
                rf_bus_in  = dbg_wdata;
                core_stall = core_valid;
                state_next = ST_DBG_ACK;
            end
            ST_DBG_ACK: begin
                if (core_valid) begin
                    rf_num1   = core_num1;
                    rf_num2   = core_num2;
                    rf_write  = norm_write(core_write);
                    rf_bus_in = core_data;
                end
                state_next = ST_RUN;
            end
            default: begin
                state_next = RESET_STATE;
            end
        endcase
        if (rst) begin
            rf_write = RF_RD;
        end
    end

    assign core_rd1 = rf_bus_out1;
    assign core_rd2 = rf_bus_out2;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Self-checking bench for regfile_ctrl. A driver issues directed and random
// core/debug traffic and pushes expected read results into queues computed
// from a plain array model of the register contents; a monitor pops and
// compares whenever the controller presents core read data or a dbg_ack.
module tb_regfile_ctrl;

    localparam int STARVE_LIMIT = 8;

    logic        clk;
    logic        rst;
    logic        core_valid;
    logic [3:0]  core_num1;
    logic [3:0]  core_num2;
    logic [1:0]  core_write;
    logic [15:0] core_data;
    logic [15:0] core_rd1;
    logic [15:0] core_rd2;
    logic        core_stall;
    logic        dbg_req;
    logic        dbg_we;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_wdata;
    logic        dbg_ack;
    logic [15:0] dbg_rdata;
    logic        busy;
    logic [3:0]  rf_num1;
    logic [3:0]  rf_num2;
    logic [1:0]  rf_write;
    logic [15:0] rf_bus_in;
    logic [15:0] rf_bus_out1;
    logic [15:0] rf_bus_out2;

    regfile_ctrl #(
        .STARVE_LIMIT   (STARVE_LIMIT),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .core_valid  (core_valid),
        .core_num1   (core_num1),
        .core_num2   (core_num2),
        .core_write  (core_write),
        .core_data   (core_data),
        .core_rd1    (core_rd1),
        .core_rd2    (core_rd2),
        .core_stall  (core_stall),
        .dbg_req     (dbg_req),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_ack     (dbg_ack),
        .dbg_rdata   (dbg_rdata),
        .busy        (busy),
        .rf_num1     (rf_num1),
        .rf_num2     (rf_num2),
        .rf_write    (rf_write),
        .rf_bus_in   (rf_bus_in),
        .rf_bus_out1 (rf_bus_out1),
        .rf_bus_out2 (rf_bus_out2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The physical register file the controller drives.
    logic [15:0] rf_mem [16];
    always @(posedge clk) begin
        if (rf_write[0]) rf_mem[rf_num1] <= rf_bus_in;
        if (rf_write[1]) rf_mem[rf_num2] <= rf_bus_in;
    end
    assign rf_bus_out1 = rf_mem[rf_num1];
    assign rf_bus_out2 = rf_mem[rf_num2];

    // Reference contents and scoreboard.
    logic [15:0] ref_mem [16];
    logic [15:0] last_rd;
    logic [31:0] core_q [$];
    logic [15:0] dbg_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    // Driver plan and debug progress: 0 idle, 1 waiting, 2 granted, 3 ack.
    logic        p_valid, p_dbg_we, dbg_start, core_hold, raised;
    logic [3:0]  p_n1, p_n2, p_dbg_addr;
    logic [1:0]  p_write;
    logic [15:0] p_data, p_dbg_wdata;
    int ph, next_ph, wait_cnt, cyc_n, req_cyc, stall_cyc, ack_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (!rst && core_valid && !core_stall && core_write == 2'b00) begin
            if (core_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL core_rd_unexpected: got %h/%h expected no read", core_rd1, core_rd2);
            end else begin
                chk("core_rd", {core_rd1, core_rd2}, core_q.pop_front());
            end
        end
        if (dbg_ack) begin
            if (dbg_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dbg_ack_unexpected: got ack expected none");
            end else begin
                chk("dbg_rdata", {16'h0, dbg_rdata}, {16'h0, dbg_q.pop_front()});
            end
        end
    end

    task automatic tick();
        logic exp_stall;
        @(posedge clk);
        #1;
        ph = next_ph;
        if (ph == 3) dbg_req = 1'b0;
        if (ph == 0 && dbg_start) begin
            dbg_req   = 1'b1;
            dbg_we    = p_dbg_we;
            dbg_addr  = p_dbg_addr;
            dbg_wdata = p_dbg_wdata;
            dbg_start = 1'b0;
            ph        = 1;
            wait_cnt  = 0;
            raised    = 1'b1;
        end
        if (!core_hold) begin
            core_valid = p_valid;
            core_num1  = p_n1;
            core_num2  = p_n2;
            core_write = p_write;
            core_data  = p_data;
        end
        @(negedge clk);
        cyc_n++;
        if (raised) begin
            req_cyc   = cyc_n;
            stall_cyc = -1;
            ack_cyc   = -1;
            raised    = 1'b0;
        end
        if (core_valid && core_stall && stall_cyc < 0) stall_cyc = cyc_n;
        if (dbg_ack && ack_cyc < 0) ack_cyc = cyc_n;
        case (ph)
            1: begin
                if (!core_valid) begin
                    next_ph = 2;
                end else begin
                    wait_cnt++;
                    next_ph = (wait_cnt == STARVE_LIMIT) ? 2 : 1;
                end
                chk("no_ack_wait", {31'h0, dbg_ack}, 32'h0);
            end
            2: begin
                if (dbg_we) ref_mem[dbg_addr] = dbg_wdata;
                else        last_rd = ref_mem[dbg_addr];
                dbg_q.push_back(last_rd);
                next_ph = 3;
            end
            3: begin
                chk("dbg_ack_pulse", {31'h0, dbg_ack}, 32'h1);
                next_ph = 0;
            end
            default: next_ph = 0;
        endcase
        exp_stall = (ph == 2) && core_valid;
        chk("core_stall", {31'h0, core_stall}, {31'h0, exp_stall});
        core_hold = exp_stall;
        if (core_valid && !exp_stall) begin
            case (core_write)
                2'b00:        core_q.push_back({ref_mem[core_num1], ref_mem[core_num2]});
                2'b01, 2'b11: ref_mem[core_num1] = core_data;
                default:      ref_mem[core_num2] = core_data;
            endcase
        end
    endtask

    task automatic core_op(input logic [3:0] n1, input logic [3:0] n2,
                           input logic [1:0] w, input logic [15:0] d);
        int n = 0;
        p_valid = 1'b1; p_n1 = n1; p_n2 = n2; p_write = w; p_data = d;
        tick();
        while (core_hold && n < 20) begin
            tick();
            n++;
        end
        p_valid = 1'b0;
    endtask

    task automatic dbg_op(input logic we, input logic [3:0] a, input logic [15:0] d);
        int n = 0;
        p_dbg_we = we; p_dbg_addr = a; p_dbg_wdata = d; dbg_start = 1'b1;
        do begin
            tick();
            n++;
        end while ((dbg_start || next_ph != 0) && n < 30);
    endtask

    initial begin
        rst = 1'b1;
        core_valid = 0; core_num1 = 0; core_num2 = 0; core_write = 0; core_data = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        p_valid = 0; p_n1 = 0; p_n2 = 0; p_write = 0; p_data = 0;
        p_dbg_we = 0; p_dbg_addr = 0; p_dbg_wdata = 0; dbg_start = 0;
        core_hold = 0; raised = 0; last_rd = 16'h0;
        ph = 0; next_ph = 0; wait_cnt = 0; cyc_n = 0;
        req_cyc = 0; stall_cyc = -1; ack_cyc = -1;
        for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0;

        // Reset, partial clear, reset again mid-clear, then a full clear.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'h1);
        chk("rst_stall", {31'h0, core_stall}, 32'h1);
        chk("rst_rf_write", {30'h0, rf_write}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("clr1_num", {28'h0, rf_num1}, i);
            chk("clr1_write", {30'h0, rf_write}, 32'h1);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_rf_write", {30'h0, rf_write}, 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'h1);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("clr_num", {28'h0, rf_num1}, i);
            chk("clr_write", {30'h0, rf_write}, 32'h1);
            chk("clr_data", {16'h0, rf_bus_in}, 32'h0);
            chk("clr_busy", {31'h0, busy}, 32'h1);
        end
        @(negedge clk);
        chk("run_busy", {31'h0, busy}, 32'h0);
        chk("run_idle_write", {30'h0, rf_write}, 32'h0);
        chk("run_idle_stall", {31'h0, core_stall}, 32'h0);

        // Directed core traffic.
        core_op(4'd3, 4'd9, 2'b00, 16'h0);
        core_op(4'd5, 4'd0, 2'b01, 16'hBEEF);
        core_op(4'd0, 4'd6, 2'b10, 16'h1234);
        core_op(4'd5, 4'd6, 2'b00, 16'h0);
        core_op(4'd2, 4'd4, 2'b11, 16'hAAAA);
        core_op(4'd2, 4'd4, 2'b00, 16'h0);

        // Debug with idle core: two-cycle turnaround.
        p_valid = 1'b0;
        dbg_op(1'b0, 4'd5, 16'h0);
        chk("dbg_idle_ack_lat", ack_cyc - req_cyc, 32'd2);
        dbg_op(1'b1, 4'd7, 16'h00FF);
        core_op(4'd7, 4'd5, 2'b00, 16'h0);

        // Debug starved by a continuously busy core.
        p_valid = 1'b1; p_n1 = 4'd1; p_n2 = 4'd2; p_write = 2'b00; p_data = 16'h0;
        p_dbg_we = 1'b0; p_dbg_addr = 4'd6; p_dbg_wdata = 16'h0; dbg_start = 1'b1;
        repeat (12) tick();
        chk("starve_stall_lat", stall_cyc - req_cyc, STARVE_LIMIT);
        chk("starve_ack_lat", ack_cyc - req_cyc, STARVE_LIMIT + 1);

        // Random mix.
        for (int c = 0; c < 400; c++) begin
            p_valid = ($urandom_range(0, 99) < 85);
            p_n1    = 4'($urandom_range(0, 15));
            p_n2    = 4'($urandom_range(0, 15));
            p_write = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            p_data  = 16'($urandom());
            if (ph == 0 && next_ph == 0 && !dbg_start && $urandom_range(0, 5) == 0) begin
                p_dbg_we    = 1'($urandom_range(0, 1));
                p_dbg_addr  = 4'($urandom_range(0, 15));
                p_dbg_wdata = 16'($urandom());
                dbg_start   = 1'b1;
            end
            tick();
        end

        // Drain and confirm every expected response appeared.
        p_valid = 1'b0;
        dbg_start = 1'b0;
        repeat (6) tick();
        chk("core_q_empty", core_q.size(), 32'd0);
        chk("dbg_q_empty", dbg_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_ctrl.md
Name: regfile_ctrl

Overview:
Owns the port of the 16x16 CPU register file and shares it between two requesters: the core execute path (latency-critical, combinational pass-through) and the debug port (req/ack handshake). After reset it runs a clear sequence that zeroes all 16 registers. It bounds debug starvation by stalling the core for one cycle once debug has waited STARVE_LIMIT cycles.

Parameters:
STARVE_LIMIT, 8, consecutive debug-wait cycles with core busy before debug is force-granted (1..255)
CLEAR_ON_RESET, 1, 1 = zero all registers after reset; 0 = go straight to RUN

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
core_valid  in  1  core accesses register file this cycle
core_num1  in  4  core read/write index, port 1
core_num2  in  4  core read/write index, port 2
core_write  in  2  bit0 = write store[num1], bit1 = write store[num2]; 00 = read
core_data  in  16  core write data
core_rd1  out  16  read data, port 1 (valid only in core read cycles)
core_rd2  out  16  read data, port 2
core_stall  out  1  core request not serviced; core holds all inputs
dbg_req  in  1  debug request; held until dbg_ack
dbg_we  in  1  1 = write, 0 = read
dbg_addr  in  4  debug register index
dbg_wdata  in  16  debug write data
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  16  registered read data, valid with dbg_ack
busy  out  1  clear sequence in progress
rf_num1  out  4  to register file num1
rf_num2  out  4  to register file num2
rf_write  out  2  to register file write
rf_bus_in  out  16  to register file bus_in
rf_bus_out1  in  16  from register file bus_out1 (Z while rf_write != 0)
rf_bus_out2  in  16  from register file bus_out2

Behaviour:
- States: CLEAR, RUN, DBG_GRANT, DBG_ACK.
- Reset (rst high): state = CLEAR if CLEAR_ON_RESET, else RUN. clr_cnt = 0, starve_cnt = 0, dbg_ack = 0, dbg_rdata = 0. rf_write = 00 while rst is high. busy and core_stall follow the reset state.
- CLEAR:
  - rf_num1 = clr_cnt, rf_write = 01, rf_bus_in = 0; busy = 1, core_stall = 1; no debug grant.
  - After the cnt = 15 cycle, go to RUN. Total 16 cycles.
  - rst mid-clear restarts at 0.
- RUN, core path: when core_valid and no grant, rf_num1/2 = core_num1/2 and rf_bus_in = core_data.
  - rf_write = core_write, except 11 is normalised to 01.
  - core_rd1/2 = rf_bus_out1/2 combinationally. Zero added latency; writes commit at the next clk edge.
- RUN, idle: no core_valid and no grant gives rf_write = 00 and rf_num1/2 = 0.
- Debug grant is issued when dbg_req and (!core_valid or starve_cnt == STARVE_LIMIT). State then goes to DBG_GRANT.
- DBG_GRANT (1 cycle):
  - rf_num1 = dbg_addr, rf_write = dbg_we ? 01 : 00, rf_bus_in = dbg_wdata.
  - core_stall = 1 if core_valid.
  - At the edge: dbg_rdata <= rf_bus_out1 for reads (unchanged for writes), dbg_ack <= 1, starve_cnt <= 0. Next state DBG_ACK.
- DBG_ACK (1 cycle):
  - dbg_ack = 1. Core is serviced as in RUN. No new grant; requester drops dbg_req this cycle.
  - Next state RUN. Minimum debug turnaround is 2 cycles.
- starve_cnt:
  - In RUN, increments (saturating at STARVE_LIMIT) each cycle with dbg_req && core_valid && no grant.
  - Clears when dbg_req = 0.
- Core and debug writing the same register: serialised by the grant, so never in the same cycle. Program order is grant order.
- core_stall = 0 in RUN and DBG_ACK. core_rd1/2 are don't-care when rf_write != 00 or when stalled.

Decomposition:
- Shared package regfile_pkg:
  - REG_COUNT = 16, REG_WIDTH = 16, REG_IDX_W = 4.
  - rf_write encodings RF_RD = 00, RF_W1 = 01, RF_W2 = 10.
  - State enum for the four states above.
- One sub-module: starve_timer (saturating counter with clear, exposes limit_hit).

Test Plan:
- Reset with CLEAR_ON_RESET=1 -> busy=1 and rf_write=01 for 16 cycles, rf_num1 stepping 0..15 with data 0. Then busy=0, and core reads of r3/r9 return 0x0000/0x0000.
- rst pulsed at clear cycle 7 -> clr_cnt restarts at 0, and 16 full clear cycles follow the release.
- Core writes r5=0xBEEF (write=01), then r6=0x1234 via write=10 on num2, next cycle reads num1=5, num2=6 -> core_rd1=0xBEEF, core_rd2=0x1234, core_stall=0 throughout. core_write=11 with num1=2, num2=4, data 0xAAAA -> only r2 written.
- Core idle, debug read r5 -> DBG_GRANT next cycle, dbg_ack=1 with dbg_rdata=0xBEEF one cycle later. Debug write r7=0x00FF -> a later core read of r7 returns 0x00FF.
- core_valid held 1 continuously with dbg_req raised at cycle t -> core_stall=1 exactly at cycle t+8 (STARVE_LIMIT=8), dbg_ack at t+9, and core is serviced again from t+9.
